// File: rtl/seq_det_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_param
// Purpose  : Runtime-programmable serial bit-sequence detector. The last
//            PAT_LEN accepted bits of inp are compared with a pattern
//            register. The block provides a same-cycle (Mealy) detect, a
//            registered copy of it, and a saturating detection counter.
//            Overlapping and non-overlapping match modes are supported.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_param #(
   parameter int                 PAT_LEN = 3,
   parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(1),
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inp,
   input  logic               en,
   input  logic               pat_ld,
   input  logic [PAT_LEN-1:0] pat_in,
   input  logic               cnt_clr,
   output logic               det,
   output logic               det_q,
   output logic [CNT_W-1:0]   det_cnt,
   output logic [PAT_LEN-1:0] pattern
);

   // fill counts valid history bits and saturates at PAT_LEN-1
   localparam int                FILL_W   = $clog2(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

   logic [PAT_LEN-1:0] pat_q,  pat_d;
   logic [PAT_LEN-2:0] hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [CNT_W-1:0]   cnt_q,  cnt_d;
   logic [PAT_LEN-1:0] window;
   logic               match;

   // The newest bit joins the history on the right; the window is compared
   // as a whole so the PAT_LEN=2 case needs no special handling.
   assign window = {hist_q, inp};

   // A load cycle never matches, and the history must be fully populated.
   assign match = en & ~pat_ld & (fill_q == FILL_MAX) & (window == pat_q);

   // rst is kept off the flop data paths; the flops are held in reset anyway,
   // so gating is only needed on the combinational output.
   assign det     = match & rst;
   assign det_cnt = cnt_q;
   assign pattern = pat_q;

   // Next-state: pattern load takes priority over sampling; a non-overlap
   // match flushes the history by restarting the fill count.
   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      if (pat_ld) begin
         pat_d  = pat_in;
         fill_d = '0;
      end else if (en) begin
         hist_d = window[PAT_LEN-2:0];
         if (match && !OVERLAP) begin
            fill_d = '0;
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + FILL_W'(1);
         end
      end
   end

   // Detection counter: clear beats a coincident match; no wrap at full scale.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State, pattern, counter and registered detect with asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q  <= PAT_RST;
         hist_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
         det_q  <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
         det_q  <= match;
      end
   end

endmodule
`default_nettype wire

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Parametrised, runtime-programmable serial bit-sequence detector.
- Compares the last PAT_LEN sampled bits on inp against a pattern register.
- Gives a Mealy (same-cycle) detect pulse, a registered copy of that pulse, and a saturating detection counter.
- Supports overlapping and non-overlapping match modes; used as the general replacement for fixed 3-bit detector FSMs.

Parameters:
PAT_LEN, 3, pattern length in bits (2..16)
PAT_RST, 3'b001, pattern register reset value; bit PAT_LEN-1 = oldest bit, bit 0 = newest bit
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history flushed after each match
CNT_W, 8, width of detection counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
inp  in  1  serial data bit
en  in  1  sample strobe; inp consumed only when en=1
pat_ld  in  1  load pat_in into pattern register
pat_in  in  PAT_LEN  new pattern value
cnt_clr  in  1  synchronous clear of det_cnt
det  out  1  Mealy detect, combinational
det_q  out  1  det registered one cycle
det_cnt  out  CNT_W  saturating count of detections
pattern  out  PAT_LEN  current pattern register value

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - pattern = PAT_RST
  - history shift register hist[PAT_LEN-2:0] = 0
  - fill counter fill = 0
  - det_q = 0, det_cnt = 0
- det is 0 whenever rst=0.
- State is {fill, hist}. fill counts valid history bits, 0..PAT_LEN-1, and saturates at PAT_LEN-1.
- Match term:
  - match = en & ~pat_ld & (fill == PAT_LEN-1) & ({hist, inp} == pattern).
  - det = match, combinational from inp/en/state, no register.
- Sample cycle (en=1, pat_ld=0):
  - hist shifts left: hist <= {hist[PAT_LEN-3:0], inp}; for PAT_LEN=2, hist <= inp.
  - fill <= min(fill+1, PAT_LEN-1).
  - If match and OVERLAP=0: fill <= 0 instead. hist may update, but its contents are don't-care.
  - If match and OVERLAP=1: fill stays PAT_LEN-1, so overlapping matches are detected.
- en=0 cycle: state holds, det=0.
- pat_ld=1:
  - pattern <= pat_in, fill <= 0.
  - The current inp sample is discarded even if en=1.
  - det=0 that cycle; takes priority over sampling.
- det_q <= det every cycle.
- det_cnt:
  - cnt_clr=1: det_cnt <= 0. Clear wins over a simultaneous match, and that match is not counted.
  - Else, on match: det_cnt <= det_cnt+1, holding at 2^CNT_W-1 (saturates, no wrap).
- The first detection is possible on the PAT_LEN-th accepted sample after reset, pattern load, or a non-overlap match.
- Reset asserted mid-stream: all history is lost; the stream must refill PAT_LEN bits before the next det.
- All-zero or all-one patterns are legal. In overlap mode with a constant input, det=1 on every sample once filled.

Test Plan:
- Defaults (001, OVERLAP=1); after reset, en=1, inp = 0,0,1,0,0,0,1 -> det=1 on samples 3 and 7 only; det_q one cycle later; det_cnt=2.
- Pattern 101 loaded via pat_ld; OVERLAP=1, inp = 1,0,1,0,1 -> det on samples 3 and 5, det_cnt=2. Same stimulus with OVERLAP=0 -> det on sample 3 only, det_cnt=1.
- en gaps: pattern 001, inp 0,(en=0, inp=1),0,1 -> no det during the gap; det on the 3rd accepted sample.
- pat_ld with en=1 while hist holds a partial match -> det=0, fill=0; the next 3 samples 0,0,1 give det=1 on the 3rd.
- CNT_W=2, 5 matches -> det_cnt saturates at 3. cnt_clr coincident with a match -> det_cnt=0, det still pulses.
- rst pulled low asynchronously mid-clock after inp 0,0 -> outputs 0 immediately. After release, a single inp=1 gives no det; 0,0,1 gives det.
